// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard controller.
// The destination field of a stage tag is sized for the widest supported
// register address, so one tag type serves every RA_W up to TAG_DST_W.
package fwd_pkg;

    localparam int unsigned TAG_DST_W = 8;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                 valid;
        logic [TAG_DST_W-1:0] dst;
        logic                 reg_write;
        logic                 mem_read;
    } stage_tag_t;

    // A stage produces a register value only if it holds a live writer.
    function automatic logic tag_writes(input stage_tag_t t);
        return t.valid & t.reg_write;
    endfunction

endpackage

// File: rtl/fwd_src_sel.sv
// Operand select for one EX source: compare against the MEM and WB
// destination tags, youngest producer first, and mux the operand.
// Loads in MEM are never forwarded; their data only exists from WB onwards.
module fwd_src_sel
    import fwd_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RA_W   = 3
) (
    input  logic [RA_W-1:0]   i_src,
    input  logic              i_src_used,
    input  stage_tag_t        i_mem_tag,
    input  stage_tag_t        i_wb_tag,
    input  logic [DATA_W-1:0] i_mem_result,
    input  logic [DATA_W-1:0] i_wb_result,
    input  logic [DATA_W-1:0] i_rf_rdata,
    output fwd_sel_e          o_sel,
    output logic [DATA_W-1:0] o_opnd
);

    logic [TAG_DST_W-1:0] w_src_wide;
    logic                 w_mem_hit;
    logic                 w_wb_hit;

    // Match detection and priority mux; MEM beats WB.
    always_comb begin
        w_src_wide             = '0;
        w_src_wide[RA_W-1:0]   = i_src;
        w_mem_hit = i_src_used & tag_writes(i_mem_tag) & ~i_mem_tag.mem_read
                    & (i_mem_tag.dst == w_src_wide);
        w_wb_hit  = i_src_used & tag_writes(i_wb_tag)
                    & (i_wb_tag.dst == w_src_wide);
        o_sel  = FWD_RF;
        o_opnd = i_rf_rdata;
        if (w_mem_hit) begin
            o_sel  = FWD_MEM;
            o_opnd = i_mem_result;
        end else if (w_wb_hit) begin
            o_sel  = FWD_WB;
            o_opnd = i_wb_result;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller: keeps the EX/MEM/WB destination-tag
// pipeline, forwards EX operands from MEM/WB, stalls decode one cycle on
// load-use, freezes on memory backpressure and squashes on ex_flush.
// Optional: define FWD_HAZARD_PERF_EN for stall/forward performance counters
// (adds perf_clr, perf_stall_cnt, perf_fwd_cnt).
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned RA_W    = 3,
    parameter int unsigned NUM_SRC = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [NUM_SRC*RA_W-1:0]   id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [RA_W-1:0]           id_dst,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      ex_flush,
    input  logic                      mem_ready,
    input  logic [DATA_W-1:0]         mem_result,
    input  logic [DATA_W-1:0]         wb_result,
    input  logic [NUM_SRC*DATA_W-1:0] rf_rdata,
    output logic [NUM_SRC*DATA_W-1:0] ex_opnd,
    output logic [NUM_SRC*2-1:0]      ex_fwd_sel,
    output logic                      stall_id,
    output logic                      bubble_ex
`ifdef FWD_HAZARD_PERF_EN
    ,
    input  logic                      perf_clr,
    output logic [31:0]               perf_stall_cnt,
    output logic [31:0]               perf_fwd_cnt
`endif
);

    stage_tag_t                r_ex;
    stage_tag_t                r_mem;
    stage_tag_t                r_wb;
    logic [NUM_SRC*RA_W-1:0]   r_ex_src;
    logic [NUM_SRC-1:0]        r_ex_src_used;

    logic [TAG_DST_W-1:0]      w_id_dst_wide;
    logic                      w_hazard;
    logic                      w_insert_bubble;

    // Load-use detection against the instruction currently in EX.
    always_comb begin
        w_id_dst_wide           = '0;
        w_id_dst_wide[RA_W-1:0] = id_dst;
        w_hazard                = 1'b0;
        if (id_valid & tag_writes(r_ex) & r_ex.mem_read) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (id_src_used[i] && (id_src[i*RA_W +: RA_W] == r_ex.dst[RA_W-1:0]))
                    w_hazard = 1'b1;
            end
        end
    end

    // Pipeline control: a flush squashes the stalled instruction, so it never stalls.
    always_comb begin
        w_insert_bubble = w_hazard | ex_flush;
        stall_id        = ~mem_ready | (w_hazard & ~ex_flush);
        bubble_ex       = mem_ready & w_insert_bubble;
    end

    // Tag pipeline: advances only when memory is ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex          <= '0;
            r_mem         <= '0;
            r_wb          <= '0;
            r_ex_src      <= '0;
            r_ex_src_used <= '0;
        end else if (mem_ready) begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            if (w_insert_bubble) begin
                r_ex          <= '0;
                r_ex_src      <= '0;
                r_ex_src_used <= '0;
            end else begin
                r_ex.valid     <= id_valid;
                r_ex.dst       <= w_id_dst_wide;
                r_ex.reg_write <= id_reg_write;
                r_ex.mem_read  <= id_mem_read;
                r_ex_src       <= id_src;
                r_ex_src_used  <= id_src_used;
            end
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        fwd_src_sel #(
            .DATA_W (DATA_W),
            .RA_W   (RA_W)
        ) u_sel (
            .i_src        (r_ex_src[g*RA_W +: RA_W]),
            .i_src_used   (r_ex_src_used[g]),
            .i_mem_tag    (r_mem),
            .i_wb_tag     (r_wb),
            .i_mem_result (mem_result),
            .i_wb_result  (wb_result),
            .i_rf_rdata   (rf_rdata[g*DATA_W +: DATA_W]),
            .o_sel        (ex_fwd_sel[g*2 +: 2]),
            .o_opnd       (ex_opnd[g*DATA_W +: DATA_W])
        );
    end

`ifdef FWD_HAZARD_PERF_EN
    logic w_any_fwd;

    // Any source taking a forwarded value this cycle.
    always_comb begin
        w_any_fwd = |ex_fwd_sel;
    end

    // Saturating counters; clear takes precedence over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_fwd_cnt   <= '0;
        end else if (perf_clr) begin
            perf_stall_cnt <= '0;
            perf_fwd_cnt   <= '0;
        end else begin
            if (stall_id && !(&perf_stall_cnt))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (w_any_fwd && !(&perf_fwd_cnt))
                perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against an instruction-level model.
module tb_fwd_hazard_ctrl;

    localparam int DW = 16;
    localparam int RW = 3;
    localparam int NS = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid;
    logic [NS*RW-1:0] id_src;
    logic [NS-1:0]    id_src_used;
    logic [RW-1:0]    id_dst;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             ex_flush;
    logic             mem_ready;
    logic [DW-1:0]    mem_result;
    logic [DW-1:0]    wb_result;
    logic [NS*DW-1:0] rf_rdata;
    logic [NS*DW-1:0] ex_opnd;
    logic [NS*2-1:0]  ex_fwd_sel;
    logic             stall_id;
    logic             bubble_ex;
`ifdef FWD_HAZARD_PERF_EN
    logic             perf_clr;
    logic [31:0]      perf_stall_cnt;
    logic [31:0]      perf_fwd_cnt;
    logic [31:0]      m_stall_cnt;
    logic [31:0]      m_fwd_cnt;
`endif

    fwd_hazard_ctrl #(
        .DATA_W  (DW),
        .RA_W    (RW),
        .NUM_SRC (NS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_src       (id_src),
        .id_src_used  (id_src_used),
        .id_dst       (id_dst),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .ex_flush     (ex_flush),
        .mem_ready    (mem_ready),
        .mem_result   (mem_result),
        .wb_result    (wb_result),
        .rf_rdata     (rf_rdata),
        .ex_opnd      (ex_opnd),
        .ex_fwd_sel   (ex_fwd_sel),
        .stall_id     (stall_id),
        .bubble_ex    (bubble_ex)
`ifdef FWD_HAZARD_PERF_EN
        ,
        .perf_clr       (perf_clr),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_fwd_cnt   (perf_fwd_cnt)
`endif
    );

    always #5 clk = ~clk;

    // One in-flight instruction as the model sees it.
    typedef struct {
        bit            v;
        logic [RW-1:0] dst;
        bit            rw;
        bit            ld;
        logic [RW-1:0] src [NS];
        bit            used [NS];
    } ins_t;

    ins_t st_ex, st_mem, st_wb;
    int   errors = 0;
    int   checks = 0;
    bit   exp_stall;
    logic [NS*2-1:0] exp_sel;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ins_t empty_ins();
        ins_t e;
        e.v = 0; e.dst = '0; e.rw = 0; e.ld = 0;
        for (int i = 0; i < NS; i++) begin
            e.src[i]  = '0;
            e.used[i] = 0;
        end
        return e;
    endfunction

    // Decode wants a value that a load in EX will only produce next cycle.
    function automatic bit m_hazard();
        logic [RW-1:0] s;
        if (!(id_valid && st_ex.v && st_ex.rw && st_ex.ld)) return 0;
        for (int i = 0; i < NS; i++) begin
            s = id_src[i*RW +: RW];
            if (id_src_used[i] && s == st_ex.dst) return 1;
        end
        return 0;
    endfunction

    task automatic check_outputs();
        bit hz;
        logic [NS*DW-1:0] eop;
        hz = m_hazard();
        exp_sel = '0;
        eop     = rf_rdata;
        for (int i = 0; i < NS; i++) begin
            if (st_ex.used[i] && st_mem.v && st_mem.rw && !st_mem.ld && st_mem.dst == st_ex.src[i]) begin
                exp_sel[i*2 +: 2] = 2'b01;
                eop[i*DW +: DW]   = mem_result;
            end else if (st_ex.used[i] && st_wb.v && st_wb.rw && st_wb.dst == st_ex.src[i]) begin
                exp_sel[i*2 +: 2] = 2'b10;
                eop[i*DW +: DW]   = wb_result;
            end
        end
        exp_stall = !mem_ready || (hz && !ex_flush);
        check("stall_id", 64'(stall_id), 64'(exp_stall));
        check("bubble_ex", 64'(bubble_ex), 64'(mem_ready && (hz || ex_flush)));
        check("ex_fwd_sel", 64'(ex_fwd_sel), 64'(exp_sel));
        check("ex_opnd", 64'(ex_opnd), 64'(eop));
`ifdef FWD_HAZARD_PERF_EN
        check("perf_stall_cnt", 64'(perf_stall_cnt), 64'(m_stall_cnt));
        check("perf_fwd_cnt", 64'(perf_fwd_cnt), 64'(m_fwd_cnt));
`endif
    endtask

    task automatic model_clear();
        st_ex  = empty_ins();
        st_mem = empty_ins();
        st_wb  = empty_ins();
`ifdef FWD_HAZARD_PERF_EN
        m_stall_cnt = '0;
        m_fwd_cnt   = '0;
`endif
    endtask

    // Called at negedge with inputs settled; leaves the bench at the next negedge.
    task automatic cyc();
        bit   hz;
        ins_t n;
        #1 check_outputs();
        hz = m_hazard();
        n  = empty_ins();
        if (!(hz || ex_flush)) begin
            n.v = id_valid; n.dst = id_dst; n.rw = id_reg_write; n.ld = id_mem_read;
            for (int i = 0; i < NS; i++) begin
                n.src[i]  = id_src[i*RW +: RW];
                n.used[i] = id_src_used[i];
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
`ifdef FWD_HAZARD_PERF_EN
            if (perf_clr) begin
                m_stall_cnt = '0;
                m_fwd_cnt   = '0;
            end else begin
                if (exp_stall && m_stall_cnt != '1) m_stall_cnt++;
                if (exp_sel != '0 && m_fwd_cnt != '1) m_fwd_cnt++;
            end
`endif
            if (mem_ready) begin
                st_wb  = st_mem;
                st_mem = st_ex;
                st_ex  = n;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_id(input bit v, input int s0, input int s1, input bit [1:0] u,
                          input int d, input bit rw, input bit ld);
        id_valid     = v;
        id_src       = {RW'(s1), RW'(s0)};
        id_src_used  = u;
        id_dst       = RW'(d);
        id_reg_write = rw;
        id_mem_read  = ld;
    endtask

    task automatic rand_data();
        mem_result = DW'($urandom);
        wb_result  = DW'($urandom);
        rf_rdata   = {DW'($urandom), DW'($urandom)};
    endtask

    initial begin
        rst_n = 1'b0; ex_flush = 0; mem_ready = 1;
`ifdef FWD_HAZARD_PERF_EN
        perf_clr = 0;
`endif
        set_id(0, 0, 0, 0, 0, 0, 0);
        rand_data();
        model_clear();
        @(negedge clk);
        cyc();
        rst_n = 1'b1;

        // 1: ALU result forwarded from MEM with no stall
        set_id(1, 0, 0, 2'b00, 1, 1, 0); cyc();
        set_id(1, 1, 3, 2'b11, 2, 1, 0); cyc();
        set_id(0, 0, 0, 2'b00, 0, 0, 0); mem_result = 16'h1234;
        #1 check("t1_sel", 64'(ex_fwd_sel), 64'h1);
        check("t1_opnd0", 64'(ex_opnd[DW-1:0]), 64'h1234);
        check("t1_stall", 64'(stall_id), 64'h0);
        cyc(); cyc(); cyc();

        // 2: load-use, one-cycle stall then WB forward on both sources
        set_id(1, 0, 0, 2'b00, 4, 1, 1); cyc();
        set_id(1, 4, 4, 2'b11, 5, 1, 0);
        #1 check("t2_stall", 64'({stall_id, bubble_ex}), 64'h3);
        cyc();
        #1 check("t2_nostall", 64'({stall_id, bubble_ex}), 64'h0);
        cyc();
        set_id(0, 0, 0, 2'b00, 0, 0, 0); wb_result = 16'hBEEF;
        #1 check("t2_sel", 64'(ex_fwd_sel), 64'hA);
        check("t2_opnd", 64'(ex_opnd), 64'hBEEFBEEF);
        cyc(); cyc(); cyc();

        // 3: same register in MEM and WB, youngest wins
        set_id(1, 0, 0, 2'b00, 6, 1, 0); cyc();
        set_id(1, 0, 0, 2'b00, 6, 1, 0); cyc();
        set_id(1, 6, 6, 2'b01, 7, 1, 0); cyc();
        set_id(0, 0, 0, 2'b00, 0, 0, 0); mem_result = 16'hAAAA; wb_result = 16'h5555;
        #1 check("t3_sel", 64'(ex_fwd_sel), 64'h1);
        check("t3_opnd0", 64'(ex_opnd[DW-1:0]), 64'hAAAA);
        cyc(); cyc(); cyc();

        // 4: backpressure during a load-use
        set_id(1, 0, 0, 2'b00, 4, 1, 1); cyc();
        set_id(1, 4, 0, 2'b01, 5, 1, 0); mem_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #1 check("t4_freeze", 64'({stall_id, bubble_ex}), 64'h2);
            cyc();
        end
        mem_ready = 1;
        #1 check("t4_hazard", 64'({stall_id, bubble_ex}), 64'h3);
        cyc();
        #1 check("t4_release", 64'(stall_id), 64'h0);
        cyc();
        set_id(0, 0, 0, 2'b00, 0, 0, 0); cyc(); cyc(); cyc();

        // 5: flush beats the load-use stall; squashed writer never forwards
        set_id(1, 0, 0, 2'b00, 4, 1, 1); cyc();
        set_id(1, 4, 4, 2'b11, 5, 1, 0); ex_flush = 1;
        #1 check("t5_flush", 64'({stall_id, bubble_ex}), 64'h1);
        cyc();
        ex_flush = 0;
        set_id(1, 5, 5, 2'b11, 2, 1, 0); cyc();
        set_id(0, 0, 0, 2'b00, 0, 0, 0);
        #1 check("t5_nofwd", 64'(ex_fwd_sel), 64'h0);
        cyc(); cyc(); cyc();

        // 6: asynchronous reset in the middle of a stall
        set_id(1, 0, 0, 2'b00, 4, 1, 1); cyc();
        set_id(1, 4, 0, 2'b01, 5, 1, 0);
        #1 check("t6_pre", 64'(stall_id), 64'h1);
        rst_n = 0;
        #1 model_clear();
        check("t6_stall", 64'(stall_id), 64'h0);
        check("t6_sel", 64'(ex_fwd_sel), 64'h0);
        @(negedge clk);
        cyc();
        rst_n = 1;
        cyc();
`ifdef FWD_HAZARD_PERF_EN
        check("t6_perf", 64'({perf_stall_cnt, perf_fwd_cnt}), 64'h0);
`endif

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            set_id($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7),
                   2'($urandom), $urandom_range(0, 7),
                   $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3);
            ex_flush  = $urandom_range(0, 9) == 0;
            mem_ready = $urandom_range(0, 9) < 8;
`ifdef FWD_HAZARD_PERF_EN
            perf_clr  = $urandom_range(0, 49) == 0;
`endif
            rand_data();
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
